// File: rtl/craps_pkg.sv
// craps_pkg: shared definitions for the craps round controller and the
// LED sum decoder.
//   phase_e            : round phase, encoding matches the 2-bit phase output
//   SUM_*              : dice sums with special meaning in craps
//   DIE_MIN / DIE_MAX  : legal face range of a single die
package craps_pkg;

    typedef enum logic [1:0] {
        PH_COME_OUT = 2'd0,
        PH_POINT    = 2'd1,
        PH_WON      = 2'd2,
        PH_LOST     = 2'd3
    } phase_e;

    localparam int SUM_2  = 2;
    localparam int SUM_3  = 3;
    localparam int SUM_7  = 7;
    localparam int SUM_11 = 11;
    localparam int SUM_12 = 12;

    localparam int DIE_MIN = 1;
    localparam int DIE_MAX = 6;

endpackage

// File: rtl/craps_sum_decode.sv
// craps_sum_decode: purely combinational roll decoder. Also used directly by
// the LED path, so the flag outputs keep their legacy meaning.
//   die_a, die_b : raw die values (DIE_W bits)
//   sum          : zero-extended die_a + die_b (SUM_W bits)
//   legal        : both dice within DIE_MIN..DIE_MAX
//   d7           : sum is 7
//   d711         : sum is 7 or 11
//   d2312        : sum is 2, 3 or 12
module craps_sum_decode
    import craps_pkg::*;
#(
    parameter int DIE_W = 3,
    parameter int SUM_W = 4
) (
    input  logic [DIE_W-1:0] die_a,
    input  logic [DIE_W-1:0] die_b,
    output logic [SUM_W-1:0] sum,
    output logic             legal,
    output logic             d7,
    output logic             d711,
    output logic             d2312
);

    logic a_ok;
    logic b_ok;

    assign a_ok  = (die_a >= DIE_W'(DIE_MIN)) && (die_a <= DIE_W'(DIE_MAX));
    assign b_ok  = (die_b >= DIE_W'(DIE_MIN)) && (die_b <= DIE_W'(DIE_MAX));
    assign legal = a_ok && b_ok;

    assign sum   = SUM_W'(die_a) + SUM_W'(die_b);

    // Flags are only meaningful when legal; the consumer gates them.
    assign d7    = (sum == SUM_W'(SUM_7));
    assign d711  = d7 || (sum == SUM_W'(SUM_11));
    assign d2312 = (sum == SUM_W'(SUM_2)) || (sum == SUM_W'(SUM_3)) ||
                   (sum == SUM_W'(SUM_12));

endmodule

// File: rtl/craps_round_fsm.sv
// craps_round_fsm: single-round craps controller.
// Takes one roll per roll_valid strobe, tracks come-out / point phases,
// holds the point, and keeps a per-round roll count plus session win/loss
// tallies. All outputs are registered (latency 1 from an accepted strobe),
// and nothing changes while clock_en is low.
//   clock, reset        : rising-edge clock, async active-high reset
//   clock_en            : qualifies every update
//   roll_valid, die_a/b : roll strobe and dice
//   new_game            : start the next round (wins over roll_valid)
//   phase, point        : round phase and established point (0 if none)
//   win, lose           : phase is WON / LOST
//   D7, D711, D2312     : class of last accepted sum
//   roll_err            : illegal die seen on a strobe (held while !clock_en)
//   roll_count          : accepted rolls this round (saturating)
//   win_count/loss_count: session tallies (saturating)
module craps_round_fsm
    import craps_pkg::*;
#(
    parameter int DIE_W = 3,
    parameter int SUM_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clock_en,
    input  logic             roll_valid,
    input  logic [DIE_W-1:0] die_a,
    input  logic [DIE_W-1:0] die_b,
    input  logic             new_game,
    output logic [1:0]       phase,
    output logic [SUM_W-1:0] point,
    output logic             win,
    output logic             lose,
    output logic             D7,
    output logic             D711,
    output logic             D2312,
    output logic             roll_err,
    output logic [CNT_W-1:0] roll_count,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] loss_count
);

    logic [SUM_W-1:0] sum;
    logic             legal;
    logic             dec_d7;
    logic             dec_d711;
    logic             dec_d2312;

    craps_sum_decode #(
        .DIE_W (DIE_W),
        .SUM_W (SUM_W)
    ) u_decode (
        .die_a (die_a),
        .die_b (die_b),
        .sum   (sum),
        .legal (legal),
        .d7    (dec_d7),
        .d711  (dec_d711),
        .d2312 (dec_d2312)
    );

    phase_e           phase_q,      phase_d;
    logic [SUM_W-1:0] point_q,      point_d;
    logic             win_q,        win_d;
    logic             lose_q,       lose_d;
    logic             d7_q,         d7_d;
    logic             d711_q,       d711_d;
    logic             d2312_q,      d2312_d;
    logic             roll_err_q,   roll_err_d;
    logic [CNT_W-1:0] roll_count_q, roll_count_d;
    logic [CNT_W-1:0] win_count_q,  win_count_d;
    logic [CNT_W-1:0] loss_count_q, loss_count_d;

    logic in_play;
    assign in_play = (phase_q == PH_COME_OUT) || (phase_q == PH_POINT);

    always_comb begin
        phase_d      = phase_q;
        point_d      = point_q;
        d7_d         = d7_q;
        d711_d       = d711_q;
        d2312_d      = d2312_q;
        roll_err_d   = roll_err_q;
        roll_count_d = roll_count_q;
        win_count_d  = win_count_q;
        loss_count_d = loss_count_q;

        if (clock_en) begin
            // Illegal dice flag in any phase, but a simultaneous new_game
            // drops the roll entirely.
            roll_err_d = roll_valid && !new_game && !legal;

            if (new_game) begin
                phase_d      = PH_COME_OUT;
                point_d      = '0;
                roll_count_d = '0;
                d7_d         = 1'b0;
                d711_d       = 1'b0;
                d2312_d      = 1'b0;
            end else if (roll_valid && legal && in_play) begin
                d7_d    = dec_d7;
                d711_d  = dec_d711;
                d2312_d = dec_d2312;
                if (roll_count_q != '1)
                    roll_count_d = roll_count_q + 1'b1;

                case (phase_q)
                    PH_COME_OUT: begin
                        if (dec_d711) begin
                            phase_d = PH_WON;
                            if (win_count_q != '1)
                                win_count_d = win_count_q + 1'b1;
                        end else if (dec_d2312) begin
                            phase_d = PH_LOST;
                            if (loss_count_q != '1)
                                loss_count_d = loss_count_q + 1'b1;
                        end else begin
                            phase_d = PH_POINT;
                            point_d = sum;
                        end
                    end
                    PH_POINT: begin
                        // Point match is tested first; a point of 7 cannot
                        // exist since 7 resolves on the come-out roll.
                        if (sum == point_q) begin
                            phase_d = PH_WON;
                            if (win_count_q != '1)
                                win_count_d = win_count_q + 1'b1;
                        end else if (dec_d7) begin
                            phase_d = PH_LOST;
                            if (loss_count_q != '1)
                                loss_count_d = loss_count_q + 1'b1;
                        end
                    end
                    default: phase_d = PH_COME_OUT;
                endcase
            end
        end

        // win/lose are registered copies of the next phase decode.
        win_d  = (phase_d == PH_WON);
        lose_d = (phase_d == PH_LOST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q      <= PH_COME_OUT;
            point_q      <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            d7_q         <= 1'b0;
            d711_q       <= 1'b0;
            d2312_q      <= 1'b0;
            roll_err_q   <= 1'b0;
            roll_count_q <= '0;
            win_count_q  <= '0;
            loss_count_q <= '0;
        end else begin
            phase_q      <= phase_d;
            point_q      <= point_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            d7_q         <= d7_d;
            d711_q       <= d711_d;
            d2312_q      <= d2312_d;
            roll_err_q   <= roll_err_d;
            roll_count_q <= roll_count_d;
            win_count_q  <= win_count_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign phase      = phase_q;
    assign point      = point_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign D7         = d7_q;
    assign D711       = d711_q;
    assign D2312      = d2312_q;
    assign roll_err   = roll_err_q;
    assign roll_count = roll_count_q;
    assign win_count  = win_count_q;
    assign loss_count = loss_count_q;

endmodule

// File: tb/tb_craps_round_fsm.sv
// tb_craps_round_fsm: table-driven directed vectors, hand sequences for
// saturation and async reset, and randomized rolls against a reference
// model of the craps rules.
module tb_craps_round_fsm;

    localparam int DIE_W = 3;
    localparam int SUM_W = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             clock_en;
    logic             roll_valid;
    logic [DIE_W-1:0] die_a;
    logic [DIE_W-1:0] die_b;
    logic             new_game;
    logic [1:0]       phase;
    logic [SUM_W-1:0] point;
    logic             win, lose, D7, D711, D2312, roll_err;
    logic [CNT_W-1:0] roll_count, win_count, loss_count;

    craps_round_fsm #(.DIE_W(DIE_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .clock_en   (clock_en),
        .roll_valid (roll_valid),
        .die_a      (die_a),
        .die_b      (die_b),
        .new_game   (new_game),
        .phase      (phase),
        .point      (point),
        .win        (win),
        .lose       (lose),
        .D7         (D7),
        .D711       (D711),
        .D2312      (D2312),
        .roll_err   (roll_err),
        .roll_count (roll_count),
        .win_count  (win_count),
        .loss_count (loss_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=come-out 1=point 2=won 3=lost.
    int m_ph, m_pt, m_rc, m_wc, m_lc;
    bit m7, m711, m2312, merr;

    typedef struct {
        bit ce, rv, ng;
        int a, b;
        int ph, pt, rc, wc, lc;
        bit [3:0] f;  // {D7, D711, D2312, roll_err}
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit ce, bit rv, bit ng, int a, int b,
                                int ph, int pt, int rc, int wc, int lc,
                                bit [3:0] f);
        vec_t v;
        v.ce = ce; v.rv = rv; v.ng = ng; v.a = a; v.b = b;
        v.ph = ph; v.pt = pt; v.rc = rc; v.wc = wc; v.lc = lc; v.f = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_exp(input string tag, input int ph, input int pt,
                             input int rc, input int wc, input int lc,
                             input bit [3:0] f);
        chk({tag, ".phase"},      32'(phase),      ph);
        chk({tag, ".point"},      32'(point),      pt);
        chk({tag, ".win"},        32'(win),        int'(ph == 2));
        chk({tag, ".lose"},       32'(lose),       int'(ph == 3));
        chk({tag, ".D7"},         32'(D7),         int'(f[3]));
        chk({tag, ".D711"},       32'(D711),       int'(f[2]));
        chk({tag, ".D2312"},      32'(D2312),      int'(f[1]));
        chk({tag, ".roll_err"},   32'(roll_err),   int'(f[0]));
        chk({tag, ".roll_count"}, 32'(roll_count), rc);
        chk({tag, ".win_count"},  32'(win_count),  wc);
        chk({tag, ".loss_count"}, 32'(loss_count), lc);
    endtask

    task automatic check_model(input string tag);
        check_exp(tag, m_ph, m_pt, m_rc, m_wc, m_lc, {m7, m711, m2312, merr});
    endtask

    task automatic model_reset();
        m_ph = 0; m_pt = 0; m_rc = 0; m_wc = 0; m_lc = 0;
        m7 = 0; m711 = 0; m2312 = 0; merr = 0;
    endtask

    task automatic model_win();
        m_ph = 2;
        if (m_wc < CMAX) m_wc++;
    endtask

    task automatic model_lose();
        m_ph = 3;
        if (m_lc < CMAX) m_lc++;
    endtask

    task automatic model_step(input bit ce, input bit rv, input bit ng,
                              input int a, input int b);
        bit ok;
        int s;
        if (!ce) return;
        ok = (a >= 1 && a <= 6 && b >= 1 && b <= 6);
        s  = a + b;
        merr = rv && !ng && !ok;
        if (ng) begin
            m_ph = 0; m_pt = 0; m_rc = 0; m7 = 0; m711 = 0; m2312 = 0;
        end else if (rv && ok && m_ph < 2) begin
            m7    = (s == 7);
            m711  = (s == 7 || s == 11);
            m2312 = (s == 2 || s == 3 || s == 12);
            if (m_rc < CMAX) m_rc++;
            if (m_ph == 0) begin
                if (m711)       model_win();
                else if (m2312) model_lose();
                else begin m_ph = 1; m_pt = s; end
            end else begin
                if (s == m_pt)  model_win();
                else if (s == 7) model_lose();
            end
        end
    endtask

    task automatic drive(input bit ce, input bit rv, input bit ng,
                         input int a, input int b);
        clock_en   = ce;
        roll_valid = rv;
        new_game   = ng;
        die_a      = DIE_W'(a);
        die_b      = DIE_W'(b);
        @(posedge clock);
        @(negedge clock);
        model_step(ce, rv, ng, a, b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clock_en = 1'b0; roll_valid = 1'b0; new_game = 1'b0;
        die_a = '0; die_b = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic int rnd_die();
        if ($urandom_range(0, 9) == 0)
            return ($urandom_range(0, 1) != 0) ? 0 : 7;
        return int'($urandom_range(1, 6));
    endfunction

    initial begin
        // ce rv ng  a  b   ph pt rc wc lc  {7,711,2312,err}
        vt.push_back(mk(1,1,0, 3,4,  2, 0,1,1,0, 4'b1100));
        vt.push_back(mk(1,0,1, 0,0,  0, 0,0,1,0, 4'b0000));
        vt.push_back(mk(1,1,0, 1,1,  3, 0,1,1,1, 4'b0010));
        vt.push_back(mk(1,1,0, 2,2,  3, 0,1,1,1, 4'b0010)); // ignored in LOST
        vt.push_back(mk(1,1,0, 0,3,  3, 0,1,1,1, 4'b0011)); // err in LOST
        vt.push_back(mk(1,0,1, 0,0,  0, 0,0,1,1, 4'b0000));
        vt.push_back(mk(1,1,0, 2,4,  1, 6,1,1,1, 4'b0000));
        vt.push_back(mk(1,1,0, 1,2,  1, 6,2,1,1, 4'b0010));
        vt.push_back(mk(1,1,0, 0,3,  1, 6,2,1,1, 4'b0011));
        vt.push_back(mk(1,1,0, 3,7,  1, 6,2,1,1, 4'b0011));
        vt.push_back(mk(0,1,0, 3,4,  1, 6,2,1,1, 4'b0011)); // ce low: hold
        vt.push_back(mk(1,1,1, 5,1,  0, 0,0,1,1, 4'b0000)); // new_game wins
        vt.push_back(mk(1,1,0, 2,4,  1, 6,1,1,1, 4'b0000));
        vt.push_back(mk(1,1,0, 1,2,  1, 6,2,1,1, 4'b0010));
        vt.push_back(mk(1,1,0, 5,1,  2, 6,3,2,1, 4'b0000));
        vt.push_back(mk(1,0,1, 0,0,  0, 0,0,2,1, 4'b0000));
        vt.push_back(mk(1,1,0, 4,4,  1, 8,1,2,1, 4'b0000));
        vt.push_back(mk(1,1,0, 6,1,  3, 8,2,2,2, 4'b1100));
        vt.push_back(mk(1,0,1, 0,0,  0, 0,0,2,2, 4'b0000));
        vt.push_back(mk(1,1,0, 5,6,  2, 0,1,3,2, 4'b0100));
        vt.push_back(mk(1,0,1, 0,0,  0, 0,0,3,2, 4'b0000));
        vt.push_back(mk(1,1,0, 6,6,  3, 0,1,3,3, 4'b0010));
        vt.push_back(mk(1,0,1, 0,0,  0, 0,0,3,3, 4'b0000));
        vt.push_back(mk(1,1,0, 1,2,  3, 0,1,3,4, 4'b0010));
        vt.push_back(mk(1,0,1, 0,0,  0, 0,0,3,4, 4'b0000));
        vt.push_back(mk(1,1,0, 5,5,  1,10,1,3,4, 4'b0000));
        vt.push_back(mk(1,1,0, 6,5,  1,10,2,3,4, 4'b0100)); // 11 in POINT
        vt.push_back(mk(1,1,0, 6,4,  2,10,3,4,4, 4'b0000));
        vt.push_back(mk(0,0,1, 0,0,  2,10,3,4,4, 4'b0000)); // ce low new_game
        vt.push_back(mk(1,1,0, 3,4,  2,10,3,4,4, 4'b0000)); // ignored in WON

        do_reset();
        check_exp("reset", 0, 0, 0, 0, 0, 4'b0000);

        foreach (vt[i]) begin
            drive(vt[i].ce, vt[i].rv, vt[i].ng, vt[i].a, vt[i].b);
            check_exp($sformatf("vec%0d", i), vt[i].ph, vt[i].pt, vt[i].rc,
                      vt[i].wc, vt[i].lc, vt[i].f);
        end

        // Random rolls, continuing from the state the table left behind.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, rnd_die(), rnd_die());
            check_model("rand");
        end

        // Win tally saturation: 256 wins from a clean reset.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 1, 0, 0);
            drive(1, 1, 0, 3, 4);
        end
        check_model("win_sat");
        chk("win_sat.count", 32'(win_count), 255);
        chk("win_sat.phase", 32'(phase), 2);

        // Loss tally saturation.
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 1, 0, 0);
            drive(1, 1, 0, 1, 1);
        end
        check_model("loss_sat");
        chk("loss_sat.count", 32'(loss_count), 255);
        chk("loss_sat.phase", 32'(phase), 3);

        // Roll count saturation while parked in POINT (point 4).
        drive(1, 0, 1, 0, 0);
        drive(1, 1, 0, 2, 2);
        for (int i = 0; i < 260; i++) drive(1, 1, 0, 1, 2);
        check_model("rc_sat");
        chk("rc_sat.count", 32'(roll_count), 255);
        chk("rc_sat.phase", 32'(phase), 1);

        // Asynchronous reset mid-POINT, asserted between clock edges.
        drive(0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 check_exp("async_rst", 0, 0, 0, 0, 0, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        drive(1, 1, 0, 3, 4);
        check_model("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
